// File: rtl/temperature_response_controller.sv
// Debounces detector low/high flags and drives heater, cooler and a latched alarm.
// Actuators have a minimum run time; the alarm is held until acknowledged.
module temperature_response_controller #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned MIN_ON   = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             sampleValid,
  input  logic             lowTempAbnormality,
  input  logic             highTempAbnormality,
  input  logic             ackAlarm,
  output logic             heaterOn,
  output logic             coolerOn,
  output logic             alarm,
  output logic [1:0]       ctrlState,
  output logic [CNT_W-1:0] eventCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HEAT  = 2'b01,
    COOL  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CLS_OK   = 2'b00,
    CLS_LOW  = 2'b01,
    CLS_HIGH = 2'b10,
    CLS_BOTH = 2'b11
  } cls_t;

  localparam logic [3:0] DEB_LIMIT  = 4'(DEBOUNCE);
  localparam logic [7:0] TIMER_LOAD = 8'(MIN_ON - 1);

  state_t     state, nextState;
  cls_t       sampleClass, prevClass, qualClass;
  logic [3:0] runCount, nextRun;
  logic [7:0] minTimer;
  logic       timerDone;
  logic       enterActuator;
  logic       enterAny;

  assign ctrlState = state;
  assign timerDone = (minTimer == 8'd0);

  // Debounce: a class qualifies when its run of identical samples reaches DEBOUNCE
  always_comb begin
    sampleClass = cls_t'({highTempAbnormality, lowTempAbnormality});
    nextRun     = 4'd1;
    if (sampleClass == prevClass) begin
      nextRun = (runCount == DEB_LIMIT) ? DEB_LIMIT : runCount + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      prevClass <= CLS_OK;
      qualClass <= CLS_OK;
      runCount  <= '0;
    end else if (sampleValid) begin
      prevClass <= sampleClass;
      runCount  <= nextRun;
      if (nextRun == DEB_LIMIT) begin
        qualClass <= sampleClass;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        unique case (qualClass)
          CLS_LOW:  nextState = HEAT;
          CLS_HIGH: nextState = COOL;
          CLS_BOTH: nextState = FAULT;
          default:  nextState = IDLE;
        endcase
      end
      HEAT: begin
        if (qualClass == CLS_BOTH) begin
          nextState = FAULT;
        end else if (timerDone) begin
          if (qualClass == CLS_OK) begin
            nextState = IDLE;
          end else if (qualClass == CLS_HIGH) begin
            nextState = COOL;
          end
        end
      end
      COOL: begin
        if (qualClass == CLS_BOTH) begin
          nextState = FAULT;
        end else if (timerDone) begin
          if (qualClass == CLS_OK) begin
            nextState = IDLE;
          end else if (qualClass == CLS_LOW) begin
            nextState = HEAT;
          end
        end
      end
      FAULT: begin
        if (ackAlarm && (qualClass != CLS_BOTH)) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign enterAny      = (nextState != state) && (nextState != IDLE);
  assign enterActuator = enterAny && ((nextState == HEAT) || (nextState == COOL));

  // Outputs are decoded from nextState so they switch on the same edge as state
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      minTimer   <= '0;
      eventCount <= '0;
      heaterOn   <= 1'b0;
      coolerOn   <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state <= nextState;
      if (enterActuator) begin
        minTimer <= TIMER_LOAD;
      end else if (!timerDone) begin
        minTimer <= minTimer - 8'd1;
      end
      if (enterAny && (eventCount != '1)) begin
        eventCount <= eventCount + CNT_W'(1);
      end
      heaterOn <= (nextState == HEAT);
      coolerOn <= (nextState == COOL);
      alarm    <= (nextState == FAULT);
    end
  end

endmodule

// File: tb/tb_temperature_response_controller.sv
// Self-checking bench for temperature_response_controller: vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_temperature_response_controller;

  localparam int DEB    = 3;
  localparam int MINON  = 16;
  localparam int CW     = 8;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          sampleValid;
  logic          lowTempAbnormality;
  logic          highTempAbnormality;
  logic          ackAlarm;
  logic          heaterOn;
  logic          coolerOn;
  logic          alarm;
  logic [1:0]    ctrlState;
  logic [CW-1:0] eventCount;

  temperature_response_controller #(
    .DEBOUNCE(DEB),
    .MIN_ON  (MINON),
    .CNT_W   (CW)
  ) dut (
    .clk                (clk),
    .rstN               (rstN),
    .sampleValid        (sampleValid),
    .lowTempAbnormality (lowTempAbnormality),
    .highTempAbnormality(highTempAbnormality),
    .ackAlarm           (ackAlarm),
    .heaterOn           (heaterOn),
    .coolerOn           (coolerOn),
    .alarm              (alarm),
    .ctrlState          (ctrlState),
    .eventCount         (eventCount)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 heat, 2 cool, 3 fault; history of recent samples
  int mMode, mAge, mQual, mCount;
  int hist[$];

  typedef struct {
    logic sv, lo, hi, ack;
    int   st, h, c, a, cnt;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode  = 0;
    mAge   = 0;
    mQual  = 0;
    mCount = 0;
    hist.delete();
  endtask

  task automatic modelEdge(input logic sv, input logic l, input logic h, input logic a);
    int  cls;
    int  nm;
    bit  held;
    bit  same;
    cls  = (h ? 2 : 0) + (l ? 1 : 0);
    nm   = mMode;
    held = (mAge + 1 >= MINON);
    case (mMode)
      0: if (mQual != 0) nm = mQual;
      1: if (mQual == 3) nm = 3;
         else if (held && mQual == 0) nm = 0;
         else if (held && mQual == 2) nm = 2;
      2: if (mQual == 3) nm = 3;
         else if (held && mQual == 0) nm = 0;
         else if (held && mQual == 1) nm = 1;
      default: if (a && mQual != 3) nm = 0;
    endcase
    if (nm != mMode && nm != 0 && mCount < CNTMAX) mCount++;
    if ((nm == 1 || nm == 2) && nm != mMode) mAge = 0;
    else if (mAge < 100000) mAge++;
    mMode = nm;
    if (sv) begin
      hist.push_back(cls);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != cls) same = 1'b0;
        if (same) mQual = cls;
      end
    end
  endtask

  task automatic step(input logic sv, input logic l, input logic h, input logic a);
    sampleValid         = sv;
    lowTempAbnormality  = l;
    highTempAbnormality = h;
    ackAlarm            = a;
    @(posedge clk);
    modelEdge(sv, l, h, a);
    #1;
    check("exclusive", int'(heaterOn & coolerOn), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkModel(input string tag);
    check({tag, "_state"},  int'(ctrlState),  mMode);
    check({tag, "_heater"}, int'(heaterOn),   int'(mMode == 1));
    check({tag, "_cooler"}, int'(coolerOn),   int'(mMode == 2));
    check({tag, "_alarm"},  int'(alarm),      int'(mMode == 3));
    check({tag, "_count"},  int'(eventCount), mCount);
  endtask

  task automatic doReset();
    rstN                = 1'b0;
    sampleValid         = 1'b0;
    lowTempAbnormality  = 1'b0;
    highTempAbnormality = 1'b0;
    ackAlarm            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(ctrlState), 0);
    check("rst_outs", int'({heaterOn, coolerOn, alarm}), 0);
    check("rst_count", int'(eventCount), 0);
    rstN = 1'b1;
    modelReset();
  endtask

  initial begin
    // sv lo hi ack | state heater cooler alarm count
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 0, 1, 2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 2};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 2};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 2};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 2};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 2};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 2};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1, 0, 3};

    // Vector table: heat entry, fault on BOTH, ack blocked then honoured, cool entry
    doReset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].sv, tbl[i].lo, tbl[i].hi, tbl[i].ack);
      check($sformatf("tbl%0d_state", i), int'(ctrlState), tbl[i].st);
      check($sformatf("tbl%0d_outs", i), int'({heaterOn, coolerOn, alarm}),
            (tbl[i].h << 2) | (tbl[i].c << 1) | tbl[i].a);
      check($sformatf("tbl%0d_count", i), int'(eventCount), tbl[i].cnt);
    end

    // Spaced strobes qualify; a broken run does not
    doReset();
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_latency", int'(ctrlState), 0);
    idle(1);
    check("t1_heat_state", int'(ctrlState), 1);
    check("t1_heater", int'(heaterOn), 1);
    check("t1_count", int'(eventCount), 1);
    doReset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("t1b_heater", int'(heaterOn), 0);
    check("t1b_count", int'(eventCount), 0);

    // Minimum on-time: OK qualified early, heater held until 16 cycles after entry
    doReset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    idle(2);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 10; e <= 20; e++) begin
      idle(1);
      check($sformatf("t2_heater_e%0d", e), int'(heaterOn), int'(e < 20));
    end
    check("t2_state", int'(ctrlState), 0);

    // Direct HEAT->COOL after the timer expires
    doReset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(17);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_still_heat", int'(heaterOn), 1);
    idle(1);
    check("t3_state", int'(ctrlState), 2);
    check("t3_outs", int'({heaterOn, coolerOn}), 1);
    check("t3_count", int'(eventCount), 2);

    // eventCount saturation
    doReset();
    for (int i = 0; i < 260; i++) begin
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(14);
      if (i == 253 || i == 254 || i == 259)
        check($sformatf("t5_count_i%0d", i), int'(eventCount), (i + 1 > CNTMAX) ? CNTMAX : i + 1);
    end
    checkModel("t5");

    // Asynchronous reset mid-COOL, then debounce restarts from zero
    doReset();
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("t6_cool_before", int'(coolerOn), 1);
    #2;
    rstN = 1'b0;
    #1;
    check("t6_async_cooler", int'(coolerOn), 0);
    check("t6_async_state", int'(ctrlState), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    modelReset();
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("t6_no_cool", int'(coolerOn), 0);
    check("t6_idle", int'(ctrlState), 0);

    // Randomized traffic against the model
    doReset();
    for (int n = 0; n < 2500; ) begin
      int   cls;
      int   hold;
      logic sv;
      logic a;
      cls  = $urandom_range(0, 3);
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        sv = ($urandom_range(0, 3) != 0);
        a  = ($urandom_range(0, 7) == 0);
        step(sv, cls[0], cls[1], a);
        checkModel("rnd");
        n++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temperature_response_controller.md
Name: temperature_response_controller

Overview:
Consumes the low/high abnormality flags produced by the temperature abnormality detection path and drives the plant's response: heater enable, cooler enable and a latched alarm. Flags are sampled on a valid strobe and debounced over consecutive samples. A state machine enforces a minimum actuator run time and holds a fault alarm until software acknowledges it. It sits downstream of the detector, between the sensing path and the actuator drivers.

Parameters:
DEBOUNCE, 3, consecutive identical samples (1..15) needed to qualify a new flag class
MIN_ON, 16, minimum cycles (2..255) HEAT/COOL is held after entry
CNT_W, 8, width of eventCount

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
sampleValid  input  1  one-cycle strobe; flags are sampled only when high
lowTempAbnormality  input  1  low-temperature flag from detector
highTempAbnormality  input  1  high-temperature flag from detector
ackAlarm  input  1  alarm acknowledge; level, honoured only in FAULT
heaterOn  output  1  heater enable
coolerOn  output  1  cooler enable
alarm  output  1  fault alarm
ctrlState  output  2  current state: 00 IDLE, 01 HEAT, 10 COOL, 11 FAULT
eventCount  output  CNT_W  saturating count of entries into HEAT, COOL or FAULT

Behaviour:
- Reset (rstN=0, async): state IDLE; heaterOn=coolerOn=alarm=0; ctrlState=00; eventCount=0; minTimer=0; prevClass=OK; runCount=0; qualClass=OK. Released synchronously at the next clk edge after rstN rises.
- Sample class from the flags: both=BOTH, low only=LOW, high only=HIGH, neither=OK.
- Debounce, on sampleValid only: if class==prevClass, runCount increments, saturating at DEBOUNCE. Otherwise runCount=1. prevClass is updated to class. If the new runCount==DEBOUNCE, qualClass is set to class at that same edge. qualClass keeps its last value between qualifications (hysteresis).
- FSM acts on the registered qualClass. Outputs are registered decodes of state: heaterOn=(HEAT), coolerOn=(COOL), alarm=(FAULT).
- Latency: the DEBOUNCE-th qualifying sample at edge N updates qualClass; the state and outputs change at edge N+1.
- IDLE:
  - qualClass LOW -> HEAT
  - qualClass HIGH -> COOL
  - qualClass BOTH -> FAULT
  - OK -> stay
- Entry into HEAT or COOL loads minTimer=MIN_ON-1. minTimer decrements every cycle while nonzero. An actuator is therefore on for at least MIN_ON cycles.
- HEAT:
  - qualClass BOTH -> FAULT immediately, ignoring minTimer
  - otherwise, while minTimer!=0, stay
  - at minTimer==0: OK -> IDLE; HIGH -> COOL (timer reloads); LOW -> stay
- COOL: mirror of HEAT, with LOW -> HEAT at minTimer==0.
- FAULT:
  - heaterOn=coolerOn=0, alarm=1
  - ackAlarm=1 and qualClass!=BOTH -> IDLE
  - ackAlarm while qualClass==BOTH is ignored; alarm stays high
  - ackAlarm in any other state has no effect
- eventCount increments by 1 on each transition into HEAT, COOL or FAULT (including HEAT->COOL) and saturates at 2^CNT_W-1. It is never cleared except by reset.
- Simultaneous events:
  - A qualification at the same edge that minTimer reaches 0 is seen by the FSM on the next cycle. No state skips a cycle.
  - sampleValid held high for multiple cycles counts one sample per cycle.
- heaterOn and coolerOn are never both 1 in any cycle, including during HEAT<->COOL transitions.
- Reset mid-operation: all outputs drop to 0 asynchronously; debounce history is lost.

Test Plan:
1. Defaults; three sampleValid pulses with low=1, high=0, the 3rd at edge N -> heaterOn=1 and ctrlState=01 after edge N+1; eventCount=1. Repeat with LOW, LOW, OK -> heaterOn stays 0 and eventCount is unchanged.
2. In HEAT, qualify OK 5 cycles after entry -> heaterOn stays 1 until 16 cycles after entry, then 0; ctrlState=00.
3. In HEAT with minTimer expired, qualify HIGH -> direct HEAT->COOL; coolerOn=1, heaterOn=0 in the same cycle; eventCount increments by 1.
4. At cycle 4 of HEAT, qualify BOTH -> FAULT at qualification+1 edge; heaterOn=0, alarm=1. ackAlarm=1 while BOTH is still qualified -> stays FAULT. Then three OK samples plus ackAlarm=1 -> IDLE, alarm=0.
5. Drive 260 alternating LOW/OK qualification sequences, each held past MIN_ON -> eventCount saturates at 255.
6. Assert rstN=0 mid-COOL, between clk edges -> coolerOn=0 immediately, ctrlState=00. After release, two HIGH samples alone do not trigger COOL (debounce restarts from zero).
